// File: rtl/char_uart_tx_pkg.sv
// Shared constants and FSM state encoding for the character UART transmitter.
package char_uart_tx_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int DEFAULT_CLKS_PER_BAUD = 104;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/char_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW; dout valid while !empty.
// Caller guarantees no write when full and no read when empty.
module char_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define occupancy.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/char_uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO; write at edge E into an idle, empty unit drives start bit from E+1.
// No backpressure to the producer: writes while full are dropped and flagged in sticky o_overflow.
module char_uart_tx
  import char_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD,
  parameter int FIFO_AW       = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_act,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int              CW       = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BAUD - 1);
  localparam logic [2:0]      BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic                      fifo_wr;
  logic                      fifo_rd;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;

  tx_state_t                 state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [2:0]                bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      tx_q, tx_n;
  logic                      ovf_q;
  logic                      cnt_done;

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for this write.
  assign fifo_wr = i_act & ~fifo_full;

  char_uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .wr_en   (fifo_wr),
    .din     (i_data),
    .rd_en   (fifo_rd),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
      ovf_q   <= ovf_q | (i_act & fifo_full);
    end
  end

  assign cnt_done = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    fifo_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_n = fifo_dout;
          tx_n    = 1'b0;
          cnt_n   = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (cnt_done) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_done) begin
          cnt_n = '0;
          if (bit_idx == BIT_LAST) begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            shift_n = {1'b0, shift[UART_DATA_BITS-1:1]};
            tx_n    = shift[1];
            bit_n   = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_done) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_tx       = tx_q;
  assign o_busy     = (state != ST_IDLE) | ~fifo_empty;
  assign o_full     = fifo_full;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_char_uart_tx.sv
// Directed bench for char_uart_tx at 4 clocks/bit, 4-deep FIFO; frames are captured bit-exact off o_tx.
module tb_char_uart_tx;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_act;
  logic       o_tx;
  logic       o_busy;
  logic       o_full;
  logic       o_overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [39:0] frame_q [$];
  int          start_q [$];

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  char_uart_tx #(
    .CLKS_PER_BAUD (4),
    .FIFO_AW       (2)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_act      (i_act),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample per cycle, bit i of the result = i-th cycle of the frame starting at the start bit.
  function automatic logic [39:0] frame_bits(input logic [7:0] d);
    logic [39:0] v;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = i / 4;
      if (k == 0)      v[i] = 1'b0;
      else if (k == 9) v[i] = 1'b1;
      else             v[i] = d[k-1];
    end
    return v;
  endfunction

  always begin : monitor
    logic [39:0] v;
    int          st;
    bit          abort;
    @(negedge i_clock); #1;
    if (!i_reset && o_tx === 1'b0) begin
      v     = '0;
      st    = cyc;
      abort = 1'b0;
      for (int i = 1; i < 40; i++) begin
        @(negedge i_clock); #1;
        if (i_reset) abort = 1'b1;
        v[i] = o_tx;
      end
      if (!abort) begin
        frame_q.push_back(v);
        start_q.push_back(st);
      end
    end
  end

  task automatic wait_frames(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (frame_q.size() < n && i < budget) begin
      @(negedge i_clock);
      i++;
    end
    check(tag, frame_q.size(), n);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_act   = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock); #2;
    frame_q.delete();
    start_q.delete();
    @(negedge i_clock);
  endtask

  task automatic check_frames(input string tag, input int n, input logic [7:0] exp_d [8]);
    int prev;
    int st;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      if (frame_q.size() > 0) begin
        st = start_q.pop_front();
        check({tag, "_data"}, frame_q.pop_front(), frame_bits(exp_d[i]));
        if (i > 0) check({tag, "_spacing"}, st - prev, 41);
        prev = st;
      end
    end
  endtask

  logic [7:0] exp3 [8];
  logic [7:0] exp4 [8];

  initial begin
    i_reset = 1'b1;
    i_act   = 1'b0;
    i_data  = 8'h00;

    // 1: reset held 3 cycles, then released
    repeat (3) begin
      @(negedge i_clock);
      check("rst_tx", o_tx, 1);
      check("rst_busy", o_busy, 0);
      check("rst_full", o_full, 0);
      check("rst_ovf", o_overflow, 0);
    end
    i_reset = 1'b0;
    @(negedge i_clock);
    check("rel_tx", o_tx, 1);
    check("rel_busy", o_busy, 0);

    // 2: single character 0x05
    i_data = 8'h05;
    i_act  = 1'b1;
    @(negedge i_clock);
    i_act = 1'b0;
    check("t2_busy_after_write", o_busy, 1);
    check("t2_tx_idle_at_write", o_tx, 1);
    repeat (40) @(negedge i_clock);
    check("t2_busy_in_stop", o_busy, 1);
    @(negedge i_clock);
    check("t2_busy_done", o_busy, 0);
    check("t2_nframes", frame_q.size(), 1);
    if (frame_q.size() > 0) begin
      check("t2_frame", frame_q.pop_front(), 40'hF00000F0F0);
      void'(start_q.pop_front());
    end

    // 3: six-cycle burst, sixth write dropped
    frame_q.delete();
    start_q.delete();
    for (int k = 0; k < 6; k++) begin
      i_data = 8'h41 + 8'(k);
      i_act  = 1'b1;
      @(negedge i_clock);
      if (k == 3) check("t3_full_e4", o_full, 0);
      if (k == 4) check("t3_full_e5", o_full, 1);
      if (k == 4) check("t3_ovf_e5", o_overflow, 0);
      if (k == 5) check("t3_ovf_e6", o_overflow, 1);
    end
    i_act = 1'b0;
    wait_frames(5, 300, "t3_wait");
    repeat (50) @(negedge i_clock);
    check("t3_nframes", frame_q.size(), 5);
    check("t3_ovf_sticky", o_overflow, 1);
    check("t3_idle", o_busy, 0);
    for (int i = 0; i < 8; i++) exp3[i] = 8'h41 + 8'(i);
    check_frames("t3", 5, exp3);

    // 6: full FIFO, write lands on the same edge as a pop
    do_reset();
    check("t6_ovf_cleared", o_overflow, 0);
    for (int k = 0; k < 5; k++) begin
      i_data = 8'h41 + 8'(k);
      i_act  = 1'b1;
      @(negedge i_clock);
    end
    i_act = 1'b0;
    check("t6_full", o_full, 1);
    repeat (37) @(negedge i_clock);
    check("t6_full_before_pop", o_full, 1);
    check("t6_ovf_before_pop", o_overflow, 0);
    i_data = 8'h99;
    i_act  = 1'b1;
    @(negedge i_clock);
    i_act = 1'b0;
    check("t6_full_after_pop", o_full, 0);
    check("t6_ovf_after_pop", o_overflow, 1);
    wait_frames(5, 400, "t6_wait");
    repeat (50) @(negedge i_clock);
    check("t6_nframes", frame_q.size(), 5);
    check_frames("t6", 5, exp3);

    // 4: producer holds i_act high; data at edge k is k
    do_reset();
    exp4 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd44, 8'd85, 8'd126};
    for (int k = 1; k <= 400 && frame_q.size() < 8; k++) begin
      i_data = 8'(k);
      i_act  = 1'b1;
      @(negedge i_clock);
      if (k == 100) begin
        check("t4_full", o_full, 1);
        check("t4_ovf", o_overflow, 1);
      end
    end
    i_act = 1'b0;
    check("t4_nframes", frame_q.size() >= 8, 1);
    check_frames("t4", 8, exp4);

    // 5: reset in the middle of the 0xA5 data bits with more queued
    do_reset();
    for (int k = 0; k < 6; k++) begin
      i_data = (k == 0) ? 8'hA5 : 8'(k * 17);
      i_act  = 1'b1;
      @(negedge i_clock);
    end
    i_act = 1'b0;
    check("t5_ovf_set", o_overflow, 1);
    repeat (14) @(negedge i_clock);
    check("t5_busy_mid", o_busy, 1);
    i_reset = 1'b1;
    @(negedge i_clock);
    check("t5_tx", o_tx, 1);
    check("t5_busy", o_busy, 0);
    check("t5_full", o_full, 0);
    check("t5_ovf", o_overflow, 0);
    i_reset = 1'b0;
    repeat (100) @(negedge i_clock);
    check("t5_no_frames", frame_q.size(), 0);
    check("t5_tx_idle", o_tx, 1);
    check("t5_busy_idle", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
